led_peak_meter: RTL and testbench
=================================

Name: led_peak_meter

Overview:
- Downstream display stage after the 256-sample audio loudness averager.
- Takes the averager's one-hot loudness word and its valid strobe, and drives an 8-LED bar graph.
- Adds a peak-hold marker with frame-based decay, and a stale-input timeout that blanks the display.

Parameters:
HOLD_FRAMES, 4, frames the peak marker holds before it starts decaying
DECAY_FRAMES, 2, frames per one-step bar decay while the input is below the bar
TIMEOUT_CYCLES, 1000000, idle clk cycles without a frame before the display blanks

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
av_valid  input  1  averager valid level, synchronous to clk; a frame = its rising edge
level_onehot  input  8  averager one-hot output; bit i set means level i+1
led_bar  output  8  thermometer code; led_bar[i]=1 iff i < bar
peak_led  output  8  one-hot at bit peak-1; all zero when peak=0
frame_pulse  output  1  one-cycle pulse when bar/peak are updated
stale  output  1  high while the display is blanked by timeout

Behaviour:
- Reset, with reset high at a clk edge:
  - state=IDLE; bar, peak, hold_cnt, decay_cnt, timeout_cnt and av_valid_q all 0.
  - All outputs are 0 in the following cycle.
  - Reset overrides any in-flight frame; no frame_pulse is produced.
- Level decode (combinational):
  - Highest set bit i of level_onehot gives L=i+1.
  - 0x00 gives L=0.
  - Multi-bit inputs are resolved by this priority; L is 4 bits, range 0..8.
- Edge detect: av_valid_q registers av_valid every cycle; event = av_valid & ~av_valid_q.
- FSM states:
  - IDLE
  - CAPTURE
  - UPDATE
  - STALE
- FSM transitions:
  - IDLE: event -> CAPTURE, latching L into lvl_r and clearing timeout_cnt. Otherwise timeout_cnt increments; at TIMEOUT_CYCLES-1 -> STALE.
  - CAPTURE: -> UPDATE unconditionally.
  - UPDATE: applies the bar/peak rules at this edge, then -> IDLE.
  - STALE: entry clears bar, peak, hold_cnt and decay_cnt; stale=1 while in STALE. Event -> CAPTURE (stale drops when leaving STALE).
- Events occurring in CAPTURE or UPDATE are dropped; av_valid_q still tracks, so only a fresh rising edge counts.
- Latency:
  - Event at edge k, state update at edge k+2.
  - frame_pulse is high for exactly the cycle after edge k+2.
  - led_bar/peak_led take new values in that same cycle.
- Bar rule (in UPDATE):
  - If L >= bar: bar=L, decay_cnt=0.
  - Else if decay_cnt==DECAY_FRAMES-1: bar=bar-1, decay_cnt=0.
  - Else decay_cnt++.
- Peak rule (in UPDATE, uses bar_next):
  - If L >= peak: peak=L, hold_cnt=HOLD_FRAMES.
  - Else if hold_cnt!=0: hold_cnt--.
  - Else peak=max(peak-1, bar_next).
  - Invariant: peak >= bar always.
- Outputs are decoded combinationally from the bar/peak registers; frame_pulse and stale are registered.
- Counter widths: timeout_cnt is $clog2(TIMEOUT_CYCLES) bits; it saturates and does not wrap.

Decomposition:
- meter_pkg holds:
  - typedef level_t (logic [3:0])
  - MAX_LEVEL=8
  - enum state_t {IDLE, CAPTURE, UPDATE, STALE}
  - functions level_to_therm and level_to_onehot
- One sub-module, onehot_level_enc: a priority encoder from the 8-bit one-hot word to level_t. It is reused by the bench model.

Test Plan:
- Reset, then one frame of 0x10 -> 2 cycles after the event edge, frame_pulse=1 for one cycle, led_bar=0x1F, peak_led=0x10, stale=0.
- Frame 0x10, then repeated 0x00 frames (HOLD=4, DECAY=2):
  - After 4 zero frames, led_bar=0x07 and peak_led=0x10.
  - 5th frame: led_bar=0x07, peak_led=0x08.
  - 6th frame: led_bar=0x03, peak_led=0x04.
- Frame with level_onehot=0x45 -> level 7, led_bar=0x7F, peak_led=0x40.
- Bench TIMEOUT_CYCLES=50, no av_valid for 50 cycles after a 0x80 frame:
  - stale=1, led_bar=0x00, peak_led=0x00.
  - The next 0x04 frame clears stale and gives led_bar=0x07.
- av_valid held high 10 cycles -> exactly one frame_pulse. av_valid low 1 cycle then high during UPDATE -> that edge is dropped, no second pulse.
- reset asserted in the UPDATE cycle of a 0x80 frame -> next cycle all outputs 0, no frame_pulse, FSM in IDLE.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared types and LED decode helpers for the LED peak meter.
// Levels run 0..8 where 0 means every LED is dark.
package meter_pkg;

   typedef logic [3:0] level_t;

   localparam level_t MAX_LEVEL = 4'd8;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      UPDATE,
      STALE
   } state_t;

   function automatic logic [7:0] level_to_therm(input level_t lvl);
      logic [7:0] therm;
      therm = '0;
      for (int i = 0; i < int'(MAX_LEVEL); i++) begin
         if (level_t'(i) < lvl) therm[i] = 1'b1;
      end
      return therm;
   endfunction

   function automatic logic [7:0] level_to_onehot(input level_t lvl);
      logic [7:0] onehot;
      onehot = '0;
      for (int i = 0; i < int'(MAX_LEVEL); i++) begin
         if (level_t'(i + 1) == lvl) onehot[i] = 1'b1;
      end
      return onehot;
   endfunction

endpackage

// File: rtl/onehot_level_enc.sv
// Priority encoder from the averager's one-hot loudness word to a level.
// The highest set bit wins, so malformed multi-bit words still decode sensibly.
module onehot_level_enc
   import meter_pkg::*;
(
   input  logic [7:0] i_onehot,
   output level_t     o_level
);

   always_comb begin
      o_level = '0;
      for (int i = 0; i < 8; i++) begin
         if (i_onehot[i]) o_level = level_t'(i + 1);
      end
   end

endmodule

// File: rtl/led_peak_meter.sv
// 8-LED bar graph with peak-hold marker, frame-based decay and stale-input blanking.
// Each rising edge of av_valid is one frame; bar/peak update two clocks later.
module led_peak_meter
   import meter_pkg::*;
#(
   parameter int HOLD_FRAMES    = 4,
   parameter int DECAY_FRAMES   = 2,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       av_valid,
   input  logic [7:0] level_onehot,
   output logic [7:0] led_bar,
   output logic [7:0] peak_led,
   output logic       frame_pulse,
   output logic       stale
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int HW = $clog2(HOLD_FRAMES + 1);
   localparam int DW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LOAD    = HW'(HOLD_FRAMES);
   localparam logic [DW-1:0] DECAY_LAST   = DW'(DECAY_FRAMES - 1);

   state_t          r_state;
   state_t          w_stateNext;
   logic            r_avValidQ;
   logic            w_event;
   level_t          w_level;
   level_t          r_lvl;
   level_t          r_bar;
   level_t          r_peak;
   level_t          w_barNext;
   level_t          w_peakNext;
   logic [HW-1:0]   r_holdCnt;
   logic [HW-1:0]   w_holdNext;
   logic [DW-1:0]   r_decayCnt;
   logic [DW-1:0]   w_decayNext;
   logic [TW-1:0]   r_timeoutCnt;
   logic            r_framePulse;
   logic            r_stale;

   onehot_level_enc u_enc (
      .i_onehot (level_onehot),
      .o_level  (w_level)
   );

   assign w_event = av_valid & ~r_avValidQ;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (w_event)                            w_stateNext = CAPTURE;
            else if (r_timeoutCnt == TIMEOUT_LAST)  w_stateNext = STALE;
         end
         CAPTURE: w_stateNext = UPDATE;
         UPDATE:  w_stateNext = IDLE;
         STALE:   if (w_event) w_stateNext = CAPTURE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Peak decay compares against the new bar so the marker never sinks below it.
   always_comb begin
      w_barNext   = r_bar;
      w_decayNext = r_decayCnt;
      if (r_lvl >= r_bar) begin
         w_barNext   = r_lvl;
         w_decayNext = '0;
      end else if (r_decayCnt == DECAY_LAST) begin
         w_barNext   = r_bar - 1'b1;
         w_decayNext = '0;
      end else begin
         w_decayNext = r_decayCnt + 1'b1;
      end

      w_peakNext = r_peak;
      w_holdNext = r_holdCnt;
      if (r_lvl >= r_peak) begin
         w_peakNext = r_lvl;
         w_holdNext = HOLD_LOAD;
      end else if (r_holdCnt != '0) begin
         w_holdNext = r_holdCnt - 1'b1;
      end else if ((r_peak - 1'b1) > w_barNext) begin
         w_peakNext = r_peak - 1'b1;
      end else begin
         w_peakNext = w_barNext;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_avValidQ   <= 1'b0;
         r_lvl        <= '0;
         r_bar        <= '0;
         r_peak       <= '0;
         r_holdCnt    <= '0;
         r_decayCnt   <= '0;
         r_timeoutCnt <= '0;
         r_framePulse <= 1'b0;
         r_stale      <= 1'b0;
      end else begin
         r_avValidQ   <= av_valid;
         r_framePulse <= 1'b0;
         r_stale      <= (w_stateNext == STALE);
         case (r_state)
            IDLE: begin
               if (w_event) begin
                  r_lvl        <= w_level;
                  r_timeoutCnt <= '0;
               end else if (r_timeoutCnt == TIMEOUT_LAST) begin
                  r_bar      <= '0;
                  r_peak     <= '0;
                  r_holdCnt  <= '0;
                  r_decayCnt <= '0;
               end else begin
                  r_timeoutCnt <= r_timeoutCnt + 1'b1;
               end
            end
            UPDATE: begin
               r_bar        <= w_barNext;
               r_peak       <= w_peakNext;
               r_holdCnt    <= w_holdNext;
               r_decayCnt   <= w_decayNext;
               r_framePulse <= 1'b1;
            end
            STALE: begin
               if (w_event) begin
                  r_lvl        <= w_level;
                  r_timeoutCnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign led_bar     = level_to_therm(r_bar);
   assign peak_led    = level_to_onehot(r_peak);
   assign frame_pulse = r_framePulse;
   assign stale       = r_stale;

endmodule

// File: tb/tb_led_peak_meter.sv
// Directed bench for led_peak_meter with hand-computed expected LED patterns.
// Uses a short timeout so the stale blanking path is reachable quickly.
module tb_led_peak_meter;
   import meter_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       av_valid;
   logic [7:0] level_onehot;
   logic [7:0] led_bar;
   logic [7:0] peak_led;
   logic       frame_pulse;
   logic       stale;

   logic [7:0] encIn;
   level_t     encOut;

   int vectorCount = 0;
   int missCount   = 0;
   int pulses;

   led_peak_meter #(
      .HOLD_FRAMES    (4),
      .DECAY_FRAMES   (2),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .av_valid     (av_valid),
      .level_onehot (level_onehot),
      .led_bar      (led_bar),
      .peak_led     (peak_led),
      .frame_pulse  (frame_pulse),
      .stale        (stale)
   );

   onehot_level_enc enc (
      .i_onehot (encIn),
      .o_level  (encOut)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in the cycle where frame_pulse should be high.
   task automatic applyStimulus(input logic [7:0] word);
      av_valid     = 1'b1;
      level_onehot = word;
      step();
      av_valid = 1'b0;
      step();
      step();
   endtask

   task automatic countPulses(input int n, output int count);
      count = 0;
      for (int i = 0; i < n; i++) begin
         if (frame_pulse) count++;
         step();
      end
   endtask

   initial begin
      reset        = 1'b1;
      av_valid     = 1'b0;
      level_onehot = 8'h00;
      encIn        = 8'h45;
      repeat (3) step();
      checkOutput("reset_bar",   led_bar,     8'h00);
      checkOutput("reset_peak",  peak_led,    8'h00);
      checkOutput("reset_pulse", {7'd0, frame_pulse}, 8'h00);
      checkOutput("reset_stale", {7'd0, stale},       8'h00);
      checkOutput("enc_0x45",    {4'd0, encOut},      8'h07);
      reset = 1'b0;
      step();

      applyStimulus(8'h10);
      checkOutput("f1_pulse", {7'd0, frame_pulse}, 8'h01);
      checkOutput("f1_bar",   led_bar,  8'h1F);
      checkOutput("f1_peak",  peak_led, 8'h10);
      checkOutput("f1_stale", {7'd0, stale}, 8'h00);
      step();
      checkOutput("f1_pulse_end", {7'd0, frame_pulse}, 8'h00);

      repeat (4) begin
         applyStimulus(8'h00);
         step();
      end
      checkOutput("z4_bar",  led_bar,  8'h07);
      checkOutput("z4_peak", peak_led, 8'h10);
      applyStimulus(8'h00);
      checkOutput("z5_bar",  led_bar,  8'h07);
      checkOutput("z5_peak", peak_led, 8'h08);
      step();
      applyStimulus(8'h00);
      checkOutput("z6_bar",  led_bar,  8'h03);
      checkOutput("z6_peak", peak_led, 8'h04);
      step();

      applyStimulus(8'h45);
      checkOutput("multi_bar",  led_bar,  8'h7F);
      checkOutput("multi_peak", peak_led, 8'h40);
      step();

      applyStimulus(8'h80);
      checkOutput("full_bar",  led_bar,  8'hFF);
      checkOutput("full_peak", peak_led, 8'h80);
      repeat (30) step();
      checkOutput("pre_stale", {7'd0, stale}, 8'h00);
      repeat (25) step();
      checkOutput("stale_flag", {7'd0, stale}, 8'h01);
      checkOutput("stale_bar",  led_bar,  8'h00);
      checkOutput("stale_peak", peak_led, 8'h00);

      applyStimulus(8'h04);
      checkOutput("recover_stale", {7'd0, stale}, 8'h00);
      checkOutput("recover_bar",   led_bar, 8'h07);
      checkOutput("recover_pulse", {7'd0, frame_pulse}, 8'h01);
      step();

      av_valid     = 1'b1;
      level_onehot = 8'h04;
      step();
      countPulses(10, pulses);
      checkOutput("held_high_pulses", 8'(pulses), 8'd1);

      av_valid = 1'b0;
      step();
      av_valid = 1'b1;
      step();
      av_valid = 1'b0;
      step();
      av_valid = 1'b1;
      countPulses(10, pulses);
      checkOutput("dropped_edge_pulses", 8'(pulses), 8'd1);

      av_valid = 1'b0;
      step();
      av_valid     = 1'b1;
      level_onehot = 8'h80;
      step();
      av_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      checkOutput("rst_upd_bar",   led_bar,  8'h00);
      checkOutput("rst_upd_peak",  peak_led, 8'h00);
      checkOutput("rst_upd_pulse", {7'd0, frame_pulse}, 8'h00);
      checkOutput("rst_upd_stale", {7'd0, stale}, 8'h00);
      checkOutput("rst_upd_state", 8'(dut.r_state), 8'(IDLE));
      reset = 1'b0;
      step();
      checkOutput("rst_upd_no_late_pulse", {7'd0, frame_pulse}, 8'h00);

      applyStimulus(8'h02);
      checkOutput("post_rst_pulse", {7'd0, frame_pulse}, 8'h01);
      checkOutput("post_rst_bar",   led_bar,  8'h03);
      checkOutput("post_rst_peak",  peak_led, 8'h02);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
